// File: rtl/game_state_ctrl.sv
// game_state_ctrl
// Frame-synchronous game sequencer. Advances a five-state game FSM once per
// vertical-blanking tick. Moves the box and maintains score and lives.
// Every output is a register, so values hold steady across the visible frame.

module game_state_ctrl #(
  parameter int FIELD_W      = 1280,
  parameter int FIELD_H      = 1024,
  parameter int BOX          = 32,
  parameter int SPEED        = 4,
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        switch,
  input  logic        hit,
  input  logic [7:0]  rnd,
  output logic [11:0] box_x,
  output logic [10:0] box_y,
  output logic [2:0]  state,
  output logic [9:0]  score,
  output logic [1:0]  lives
);

  // Playfield geometry.
  localparam int X_MAX = FIELD_W - BOX;
  localparam int Y_MAX = FIELD_H - BOX;
  localparam logic [11:0] X_CTR = 12'(X_MAX / 2);
  localparam logic [10:0] Y_CTR = 11'(Y_MAX / 2);

  // Positions are stepped in 13-bit signed arithmetic so that a step past
  // either edge can be detected before it is clamped.
  localparam logic signed [12:0] X_MAX_S = 13'(X_MAX);
  localparam logic signed [12:0] Y_MAX_S = 13'(Y_MAX);
  localparam logic signed [12:0] SPD_S   = 13'(SPEED);

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  localparam int CNT_W = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Switch synchroniser and edge detector.
  logic s1, s2, s3;
  logic rise;

  // Hit latch: remembers any hit seen since the last consumed tick.
  logic hl;
  logic hit_seen;
  logic tick_taken;

  // Game datapath registers. Direction is stored as a sign bit
  // (1 = moving toward larger coordinates, i.e. +SPEED).
  logic [11:0]      x_q, x_d;
  logic [10:0]      y_q, y_d;
  logic             dx_pos_q, dx_pos_d;
  logic             dy_pos_q, dy_pos_d;
  logic [9:0]       score_q, score_d;
  logic [1:0]       lives_q, lives_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Result of one PLAY-state movement step, before the FSM decides on it.
  logic signed [12:0] nx, ny;
  logic [11:0]        play_x;
  logic [10:0]        play_y;
  logic               play_dx_pos;
  logic               play_dy_pos;
  logic [9:0]         play_score;
  logic               play_miss;

  // Only the two direction bits of the random word are used at launch.
  logic unused_rnd_bits;
  assign unused_rnd_bits = ^rnd[7:2];

  // Three-flop chain for the asynchronous switch. s3 is the edge-detect delay.
  always_ff @(posedge clock) begin
    // NOTE: clocked state is written with non-blocking assignments, so every
    // flop samples the pre-edge value of its neighbour (a true shift chain).
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= switch;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise       = s2 & ~s3;
  // A tick that coincides with a switch edge is dropped entirely.
  assign tick_taken = frame_tick & ~rise;
  // A hit in the tick cycle itself counts toward that tick.
  assign hit_seen   = hl | hit;

  // Hit latch: set by any hit, cleared once a tick has consumed it.
  always_ff @(posedge clock) begin
    if (reset) begin
      hl <= 1'b0;
    end else if (tick_taken) begin
      hl <= 1'b0;
    end else if (hit) begin
      hl <= 1'b1;
    end
  end

  // One movement step of the box: walls on x, paddle/ceiling/floor on y.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the branches leaves a value unassigned (no latches).
    nx          = $signed({1'b0, x_q}) + (dx_pos_q ? SPD_S : -SPD_S);
    ny          = $signed({2'b00, y_q}) + (dy_pos_q ? SPD_S : -SPD_S);
    play_x      = x_q;
    play_y      = y_q;
    play_dx_pos = dx_pos_q;
    play_dy_pos = dy_pos_q;
    play_score  = score_q;
    play_miss   = 1'b0;

    // Horizontal: bounce off the left and right walls.
    if (nx[12]) begin
      play_x      = '0;
      play_dx_pos = 1'b1;
    end else if (nx > X_MAX_S) begin
      play_x      = 12'(X_MAX);
      play_dx_pos = 1'b0;
    end else begin
      play_x = nx[11:0];
    end

    // Vertical: a paddle hit wins over the ceiling and floor checks.
    if (hit_seen) begin
      play_dy_pos = 1'b0;
      if (ny[12]) begin
        play_y = '0;
      end else if (ny > Y_MAX_S) begin
        play_y = 11'(Y_MAX);
      end else begin
        play_y = ny[10:0];
      end
      // Only a hit on a descending box scores; the score saturates.
      if (dy_pos_q && (score_q != '1)) begin
        play_score = score_q + 10'd1;
      end
    end else if (ny[12]) begin
      play_y      = '0;
      play_dy_pos = 1'b1;
    end else if (ny > Y_MAX_S) begin
      play_miss = 1'b1;
    end else begin
      play_y = ny[10:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath update. A switch edge has priority over the tick.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_pos_d = dx_pos_q;
    dy_pos_d = dy_pos_q;
    score_d  = score_q;
    lives_d  = lives_q;
    cnt_d    = cnt_q;

    if (rise) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SERVE;
          cnt_d   = CNT_LOAD;
        end
        ST_PLAY:  state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_PLAY;
        ST_OVER: begin
          state_d = ST_IDLE;
          x_d     = X_CTR;
          y_d     = Y_CTR;
          score_d = '0;
          lives_d = LIVES_INIT;
        end
        ST_SERVE: ;
        default:  state_d = ST_IDLE;
      endcase
    end else if (frame_tick) begin
      case (state_q)
        ST_SERVE: begin
          // The tick that finds the counter at 1 launches the box.
          if (cnt_q <= CNT_ONE) begin
            state_d  = ST_PLAY;
            cnt_d    = '0;
            dx_pos_d = rnd[0];
            dy_pos_d = rnd[1];
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_PLAY: begin
          x_d      = play_x;
          y_d      = play_y;
          dx_pos_d = play_dx_pos;
          dy_pos_d = play_dy_pos;
          score_d  = play_score;
          if (play_miss) begin
            lives_d = lives_q - 2'd1;
            if (lives_q == 2'd1) begin
              // Last life lost: the box stays where it was.
              state_d = ST_OVER;
              x_d     = x_q;
            end else begin
              state_d = ST_SERVE;
              x_d     = X_CTR;
              y_d     = Y_CTR;
              cnt_d   = CNT_LOAD;
            end
          end
        end
        ST_IDLE, ST_PAUSE, ST_OVER: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Game datapath registers, reset to the IDLE picture.
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q      <= X_CTR;
      y_q      <= Y_CTR;
      dx_pos_q <= 1'b1;
      dy_pos_q <= 1'b1;
      score_q  <= '0;
      lives_q  <= LIVES_INIT;
      cnt_q    <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      dx_pos_q <= dx_pos_d;
      dy_pos_q <= dy_pos_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      cnt_q    <= cnt_d;
    end
  end

  assign box_x = x_q;
  assign box_y = y_q;
  assign state = state_q;
  assign score = score_q;
  assign lives = lives_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Testbench for game_state_ctrl. Randomised frames checked against a
// behavioural game model (plain integers, signed velocities).

module tb_game_state_ctrl;

  localparam int XM  = 1248;  // FIELD_W - BOX
  localparam int YM  = 992;   // FIELD_H - BOX
  localparam int XC  = 624;
  localparam int YC  = 496;
  localparam int SPD = 4;
  localparam int NL  = 3;
  localparam int SF  = 60;

  localparam int M_IDLE  = 0;
  localparam int M_SERVE = 1;
  localparam int M_PLAY  = 2;
  localparam int M_PAUSE = 3;
  localparam int M_OVER  = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        switch = 1'b0;
  logic        hit = 1'b0;
  logic [7:0]  rnd = 8'd0;
  logic [11:0] box_x;
  logic [10:0] box_y;
  logic [2:0]  state;
  logic [9:0]  score;
  logic [1:0]  lives;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the game.
  int m_state = M_IDLE;
  int m_x = XC, m_y = YC, m_dx = SPD, m_dy = SPD;
  int m_score = 0, m_lives = NL, m_cnt = 0;
  bit m_hl = 1'b0;
  bit m_s1 = 1'b0, m_s2 = 1'b0, m_s3 = 1'b0;

  game_state_ctrl #(
    .FIELD_W(1280), .FIELD_H(1024), .BOX(32), .SPEED(4), .LIVES(3), .SERVE_FRAMES(60)
  ) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .switch(switch),
    .hit(hit), .rnd(rnd), .box_x(box_x), .box_y(box_y), .state(state),
    .score(score), .lives(lives)
  );

  always #5 clock = ~clock;

  task automatic model_play(input bit hseen);
    int nx, ny, ox;
    nx = m_x + m_dx;
    ny = m_y + m_dy;
    ox = m_x;
    if (nx < 0) begin m_x = 0; m_dx = SPD; end
    else if (nx > XM) begin m_x = XM; m_dx = -SPD; end
    else m_x = nx;
    if (hseen) begin
      if (m_dy > 0 && m_score < 1023) m_score++;
      m_dy = -SPD;
      m_y = (ny > YM) ? YM : ((ny < 0) ? 0 : ny);
    end else if (ny < 0) begin
      m_y = 0; m_dy = SPD;
    end else if (ny > YM) begin
      m_lives--;
      if (m_lives == 0) begin
        m_state = M_OVER; m_x = ox;
      end else begin
        m_state = M_SERVE; m_x = XC; m_y = YC; m_cnt = SF;
      end
    end else m_y = ny;
  endtask

  // One clock edge of the model, using the inputs the DUT just sampled.
  task automatic model_update();
    bit rise, hseen;
    if (reset) begin
      m_state = M_IDLE; m_x = XC; m_y = YC; m_dx = SPD; m_dy = SPD;
      m_score = 0; m_lives = NL; m_cnt = 0; m_hl = 0;
      m_s1 = 0; m_s2 = 0; m_s3 = 0;
      return;
    end
    rise  = m_s2 && !m_s3;
    hseen = m_hl || hit;
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = switch;
    m_hl = (frame_tick && !rise) ? 1'b0 : hseen;
    if (rise) begin
      case (m_state)
        M_IDLE:  begin m_state = M_SERVE; m_cnt = SF; end
        M_PLAY:  m_state = M_PAUSE;
        M_PAUSE: m_state = M_PLAY;
        M_OVER:  begin m_state = M_IDLE; m_x = XC; m_y = YC; m_score = 0; m_lives = NL; end
        default: ;
      endcase
    end else if (frame_tick) begin
      if (m_state == M_SERVE) begin
        if (m_cnt <= 1) begin
          m_state = M_PLAY; m_cnt = 0;
          m_dx = rnd[0] ? SPD : -SPD;
          m_dy = rnd[1] ? SPD : -SPD;
        end else m_cnt--;
      end else if (m_state == M_PLAY) begin
        model_play(hseen);
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge; outputs are read #1 after the rising edge.
  task automatic step(input bit rs, input bit tk, input bit sw, input bit ht, input int r);
    @(negedge clock);
    reset = rs; frame_tick = tk; switch = sw; hit = ht;
    rnd = (r < 0) ? 8'($urandom) : 8'(r);
    @(posedge clock);
    model_update();
    #1;
  endtask

  // A four-cycle frame; the tick is in the last cycle, an optional hit anywhere.
  task automatic frame(input bit want_hit, input int r);
    int hp;
    hp = $urandom_range(0, 3);
    for (int c = 0; c < 4; c++) step(1'b0, c == 3, 1'b0, want_hit && (c == hp), r);
  endtask

  function automatic bit alive_hit();
    if (m_state != M_PLAY) return $urandom_range(0, 5) == 0;
    if (m_dy > 0 && m_y >= YM - 8) return 1'b1;
    return (m_y >= 16) && ($urandom_range(0, 9) == 0);
  endfunction

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    n_checks++;
    if (state !== 3'd0 || box_x !== 12'd624 || box_y !== 11'd496 || score !== 10'd0 || lives !== 2'd3) begin
      n_fail++;
      $display("FAIL reset_values: got st=%0d x=%0d y=%0d sc=%0d lv=%0d, want 0 624 496 0 3",
               state, box_x, box_y, score, lives);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_serve();
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 0);
      if (c == 1 || c == 2) begin
        n_checks++;
        if (state !== ((c == 2) ? 3'd1 : 3'd0)) begin
          n_fail++;
          $display("FAIL switch_latency edge%0d: got st=%0d want %0d", c + 1, state, (c == 2) ? 1 : 0);
        end
      end
    end
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 1; i <= SF; i++) begin
      frame($urandom_range(0, 3) == 0, 3);
      n_checks++;
      if ({state, box_x, box_y, score, lives} !== {3'(m_state), 12'(m_x), 11'(m_y), 10'(m_score), 2'(m_lives)}) begin
        n_fail++;
        $display("FAIL serve_frame%0d: got st=%0d x=%0d y=%0d sc=%0d lv=%0d, want st=%0d x=%0d y=%0d sc=%0d lv=%0d",
                 i, state, box_x, box_y, score, lives, m_state, m_x, m_y, m_score, m_lives);
      end
      if (i == SF - 1 || i == SF) begin
        n_checks++;
        if (state !== ((i == SF) ? 3'd2 : 3'd1)) begin
          n_fail++;
          $display("FAIL serve_duration tick%0d: got st=%0d want %0d", i, state, (i == SF) ? 2 : 1);
        end
      end
    end
    frame(1'b0, 0);
    n_checks++;
    if (box_x !== 12'd628 || box_y !== 11'd500) begin
      n_fail++;
      $display("FAIL first_move: got x=%0d y=%0d want 628 500", box_x, box_y);
    end
  endtask

  task automatic test_play();
    bit pending = 1'b0;
    bit done = 1'b0;
    for (int i = 0; i < 320; i++) begin
      frame(alive_hit(), -1);
      n_checks++;
      if ({state, box_x, box_y, score, lives} !== {3'(m_state), 12'(m_x), 11'(m_y), 10'(m_score), 2'(m_lives)}) begin
        n_fail++;
        $display("FAIL play_frame%0d: got st=%0d x=%0d y=%0d sc=%0d lv=%0d, want st=%0d x=%0d y=%0d sc=%0d lv=%0d",
                 i, state, box_x, box_y, score, lives, m_state, m_x, m_y, m_score, m_lives);
      end
      if (pending) begin
        pending = 1'b0;
        done = 1'b1;
        n_checks++;
        if (box_x !== 12'd1244) begin
          n_fail++;
          $display("FAIL right_wall_return: got x=%0d want 1244", box_x);
        end
      end else if (!done && m_x == XM && m_dx < 0) begin
        pending = 1'b1;
        n_checks++;
        if (box_x !== 12'd1248) begin
          n_fail++;
          $display("FAIL right_wall_clamp: got x=%0d want 1248", box_x);
        end
      end
    end
  endtask

  task automatic test_pause();
    int px, py, pdx;
    px = m_x; py = m_y; pdx = m_dx;
    // Switch sampled at the first of these edges; rise lands on the tick cycle.
    step(1'b0, 1'b0, 1'b1, 1'b0, -1);
    step(1'b0, 1'b0, 1'b1, 1'b0, -1);
    step(1'b0, 1'b1, 1'b1, 1'b0, -1);
    n_checks++;
    if (state !== 3'd3 || box_x !== 12'(px) || box_y !== 11'(py)) begin
      n_fail++;
      $display("FAIL pause_on_tick: got st=%0d x=%0d y=%0d want 3 %0d %0d", state, box_x, box_y, px, py);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 100; i++) begin
      frame($urandom_range(0, 2) == 0, -1);
      n_checks++;
      if ({state, box_x, box_y, score, lives} !== {3'(m_state), 12'(m_x), 11'(m_y), 10'(m_score), 2'(m_lives)}) begin
        n_fail++;
        $display("FAIL pause_frame%0d: got st=%0d x=%0d y=%0d sc=%0d lv=%0d, want st=%0d x=%0d y=%0d sc=%0d lv=%0d",
                 i, state, box_x, box_y, score, lives, m_state, m_x, m_y, m_score, m_lives);
      end
    end
    n_checks++;
    if (box_x !== 12'(px) || box_y !== 11'(py)) begin
      n_fail++;
      $display("FAIL pause_frozen: got x=%0d y=%0d want %0d %0d", box_x, box_y, px, py);
    end
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, c < 2, 1'b0, -1);
    n_checks++;
    if (state !== 3'd2) begin
      n_fail++;
      $display("FAIL resume_state: got st=%0d want 2", state);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 20; i++) begin
      frame(alive_hit(), -1);
      n_checks++;
      if ({state, box_x, box_y, score, lives} !== {3'(m_state), 12'(m_x), 11'(m_y), 10'(m_score), 2'(m_lives)}) begin
        n_fail++;
        $display("FAIL resume_frame%0d: got st=%0d x=%0d y=%0d sc=%0d lv=%0d, want st=%0d x=%0d y=%0d sc=%0d lv=%0d",
                 i, state, box_x, box_y, score, lives, m_state, m_x, m_y, m_score, m_lives);
      end
      if (i == 0 && px >= 8 && px <= XM - 8) begin
        n_checks++;
        if (box_x !== 12'(px + pdx)) begin
          n_fail++;
          $display("FAIL resume_direction: got x=%0d want %0d", box_x, px + pdx);
        end
      end
    end
  endtask

  task automatic test_miss();
    int prev;
    int guard = 0;
    while (m_state != M_OVER && guard < 2500) begin
      prev = m_state;
      frame((m_state != M_PLAY) && ($urandom_range(0, 3) == 0), -1);
      guard++;
      n_checks++;
      if ({state, box_x, box_y, score, lives} !== {3'(m_state), 12'(m_x), 11'(m_y), 10'(m_score), 2'(m_lives)}) begin
        n_fail++;
        $display("FAIL miss_frame%0d: got st=%0d x=%0d y=%0d sc=%0d lv=%0d, want st=%0d x=%0d y=%0d sc=%0d lv=%0d",
                 guard, state, box_x, box_y, score, lives, m_state, m_x, m_y, m_score, m_lives);
      end
      if (prev == M_PLAY && m_state == M_SERVE) begin
        n_checks++;
        if (state !== 3'd1 || box_x !== 12'd624 || box_y !== 11'd496 || lives !== 2'(m_lives)) begin
          n_fail++;
          $display("FAIL miss_recentre: got st=%0d x=%0d y=%0d lv=%0d want 1 624 496 %0d",
                   state, box_x, box_y, lives, m_lives);
        end
      end
    end
    n_checks++;
    if (state !== 3'd4 || lives !== 2'd0) begin
      n_fail++;
      $display("FAIL game_over: got st=%0d lv=%0d want 4 0 (frames=%0d)", state, lives, guard);
    end
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, c < 2, 1'b0, -1);
    n_checks++;
    if (state !== 3'd0 || score !== 10'd0 || lives !== 2'd3 || box_x !== 12'd624 || box_y !== 11'd496) begin
      n_fail++;
      $display("FAIL over_to_idle: got st=%0d sc=%0d lv=%0d x=%0d y=%0d want 0 0 3 624 496",
               state, score, lives, box_x, box_y);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_reset_mid_game();
    int guard = 0;
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, c < 2, 1'b0, -1);
    for (int i = 0; i < SF; i++) frame(1'b0, -1);
    while (m_score < 7 && guard < 1500) begin
      frame(m_state == M_PLAY && m_dy > 0, -1);
      guard++;
      n_checks++;
      if ({state, box_x, box_y, score, lives} !== {3'(m_state), 12'(m_x), 11'(m_y), 10'(m_score), 2'(m_lives)}) begin
        n_fail++;
        $display("FAIL score_frame%0d: got st=%0d x=%0d y=%0d sc=%0d lv=%0d, want st=%0d x=%0d y=%0d sc=%0d lv=%0d",
                 guard, state, box_x, box_y, score, lives, m_state, m_x, m_y, m_score, m_lives);
      end
    end
    n_checks++;
    if (state !== 3'd2 || score !== 10'd7) begin
      n_fail++;
      $display("FAIL score_seven: got st=%0d sc=%0d want 2 7 (frames=%0d)", state, score, guard);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, -1);
    n_checks++;
    if (state !== 3'd0 || box_x !== 12'd624 || box_y !== 11'd496 || score !== 10'd0 || lives !== 2'd3) begin
      n_fail++;
      $display("FAIL reset_mid_game: got st=%0d x=%0d y=%0d sc=%0d lv=%0d, want 0 624 496 0 3",
               state, box_x, box_y, score, lives);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_serve();
    test_play();
    test_pause();
    test_miss();
    test_reset_mid_game();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
